riscv_mc_ctrl: RTL and testbench

Multi-cycle control sequencer for the RV32I core datapath. Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the enables and selects for PC, IR, register file and memory port. Handshakes with a single shared instruction/data memory port via req/ready. Counts retired instructions and halts on SYSTEM, on a memory timeout, or, when the optional trap is compiled in, on an illegal opcode.

---
 rtl/riscv_mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the RV32I core datapath.
// Define RISCV_CTRL_ILLEGAL_TRAP_EN to halt on illegal opcodes instead of retiring them as NOPs.
module riscv_mc_ctrl #(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [6:0]       opcode,
   input  logic             is_store_hint,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_we,
   output logic             pc_we,
   output logic             pc_sel,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic [2:0]       state,
   output logic             halted,
   output logic [1:0]       halt_cause,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU, CLS_JUMP, CLS_BRANCH, CLS_LOAD, CLS_STORE, CLS_SYSTEM, CLS_ILLEGAL
   } cls_t;

   // The watchdog only ever counts up to MEM_TIMEOUT-1 before the FSM leaves the request state.
   localparam int              WD_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
   localparam bit              WD_EN    = (MEM_TIMEOUT != 0);

   state_t           state_q, state_d;
   cls_t             cls_q, cls_d;
   logic [1:0]       cause_q, cause_d;
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [WD_W-1:0]  wdog_q, wdog_d;
   logic             retire;
   logic             wdHit;
   logic             unused_hint;

   assign unused_hint = is_store_hint;
   assign wdHit       = WD_EN && (wdog_q == WD_LIMIT);

   function automatic cls_t decodeClass(input logic [6:0] op);
      case (op)
         7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: decodeClass = CLS_ALU;
         7'b1101111, 7'b1100111:                         decodeClass = CLS_JUMP;
         7'b1100011:                                     decodeClass = CLS_BRANCH;
         7'b0000011:                                     decodeClass = CLS_LOAD;
         7'b0100011:                                     decodeClass = CLS_STORE;
         7'b1110011:                                     decodeClass = CLS_SYSTEM;
         default:                                        decodeClass = CLS_ILLEGAL;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         cls_q     <= CLS_ALU;
         cause_q   <= 2'd0;
         instret_q <= '0;
         wdog_q    <= '0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         cause_q   <= cause_d;
         instret_q <= instret_d;
         wdog_q    <= wdog_d;
      end
   end

   // Every strobe is forced low while rst is high, whatever state the register still holds.
   always_comb begin
      state_d      = state_q;
      cls_d        = cls_q;
      cause_d      = cause_q;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_sel       = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'd0;
      retire       = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_FETCH: begin
               if (run) begin
                  mem_req = 1'b1;
                  if (mem_ready) begin
                     ir_we   = 1'b1;
                     state_d = ST_DECODE;
                  end else if (wdHit) begin
                     state_d = ST_HALT;
                     cause_d = 2'd3;
                  end
               end
            end
            ST_DECODE: begin
               cls_d = decodeClass(opcode);
               if (cls_d == CLS_SYSTEM) begin
                  state_d = ST_HALT;
                  cause_d = 2'd1;
               end
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
               else if (cls_d == CLS_ILLEGAL) begin
                  state_d = ST_HALT;
                  cause_d = 2'd2;
               end
`endif
               else begin
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               case (cls_q)
                  CLS_ALU, CLS_JUMP:   state_d = ST_WB;
                  CLS_LOAD, CLS_STORE: state_d = ST_MEM;
                  CLS_BRANCH: begin
                     pc_we   = 1'b1;
                     pc_sel  = branch_taken;
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end
                  default: begin
                     pc_we   = 1'b1;
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end
               endcase
            end
            ST_MEM: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               mem_we       = (cls_q == CLS_STORE);
               if (mem_ready) begin
                  if (cls_q == CLS_STORE) begin
                     pc_we   = 1'b1;
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end else begin
                     state_d = ST_WB;
                  end
               end else if (wdHit) begin
                  state_d = ST_HALT;
                  cause_d = 2'd3;
               end
            end
            ST_WB: begin
               reg_we  = 1'b1;
               pc_we   = 1'b1;
               retire  = 1'b1;
               state_d = ST_FETCH;
               case (cls_q)
                  CLS_LOAD: wb_sel = 2'd1;
                  CLS_JUMP: begin
                     wb_sel = 2'd2;
                     pc_sel = 1'b1;
                  end
                  default:  wb_sel = 2'd0;
               endcase
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_FETCH;
         endcase
      end
      instret_d = instret_q + CNT_W'(retire);
      wdog_d    = (mem_req && !mem_ready) ? wdog_q + WD_W'(1) : '0;
   end

   assign state      = state_q;
   assign halted     = (state_q == ST_HALT);
   assign halt_cause = cause_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Randomized scoreboard bench for riscv_mc_ctrl; honours RISCV_CTRL_ILLEGAL_TRAP_EN like the design.
module tb_riscv_mc_ctrl;

   localparam int CNT_W = 4;
   localparam int TO    = 8;
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst, run, is_store_hint, branch_taken, mem_ready;
   logic [6:0]       opcode;
   logic             mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel, reg_we, halted;
   logic [1:0]       wb_sel, halt_cause;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   riscv_mc_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .run(run), .opcode(opcode), .is_store_hint(is_store_hint),
      .branch_taken(branch_taken), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr_sel(mem_addr_sel), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .halted(halted),
      .halt_cause(halt_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   typedef enum {K_ALU, K_JUMP, K_BRANCH, K_LOAD, K_STORE, K_SYSTEM, K_ILL} kind_t;

   typedef struct {
      bit               isHalt;
      logic [1:0]       cause;
      int               lat;
      logic             pcSel;
      logic [1:0]       wbSel;
      int               regWes;
      int               memCycles;
      int               weCycles;
      logic [CNT_W-1:0] instretBefore;
   } exp_t;

   exp_t sbQ[$];
   int   nChecks = 0;
   int   nFail = 0;
   int   modelCount = 0;

   int   monLat = 0, monMem = 0, monWe = 0, monReg = 0;
   bit   monPrevHalted = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic kind_t classify(input logic [6:0] op);
      case (op)
         7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: return K_ALU;
         7'b1101111, 7'b1100111:                         return K_JUMP;
         7'b1100011:                                     return K_BRANCH;
         7'b0000011:                                     return K_LOAD;
         7'b0100011:                                     return K_STORE;
         7'b1110011:                                     return K_SYSTEM;
         default:                                        return K_ILL;
      endcase
   endfunction

   // Total cycles from the first fetch cycle to retirement when memory answers at once.
   function automatic int zeroWaitLatency(input kind_t k);
      case (k)
         K_ALU, K_JUMP, K_STORE: return 4;
         K_LOAD:                 return 5;
         default:                return 3;
      endcase
   endfunction

   function automatic logic [6:0] randomOpcode();
      logic [6:0] legal [9] = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011, 7'b1101111,
                                7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011};
      logic [6:0] op;
      if (!TRAP && $urandom_range(0, 7) == 0) begin
         op = 7'($urandom);
         if (classify(op) != K_ILL) op = 7'b0000000;
      end else begin
         op = legal[$urandom_range(0, 8)];
      end
      return op;
   endfunction

   // fw: fetch wait cycles, mw: memory wait cycles; a wait of TO or more ends in a timeout halt.
   task automatic applyStimulus(input logic [6:0] op, input int fw, input int mw, input bit taken);
      kind_t k  = classify(op);
      bit    ls = (k == K_LOAD) || (k == K_STORE);
      exp_t  e;
      int    total;
      e.isHalt = 1'b1; e.cause = 2'd0; e.lat = 0; e.pcSel = 1'b0; e.wbSel = 2'd0;
      e.regWes = 0; e.memCycles = 0; e.weCycles = 0; e.instretBefore = '0;
      if (fw >= TO) begin
         e.cause = 2'd3; total = TO;
      end else if (k == K_SYSTEM) begin
         e.cause = 2'd1; total = fw + 2;
      end else if (k == K_ILL && TRAP) begin
         e.cause = 2'd2; total = fw + 2;
      end else if (ls && mw >= TO) begin
         e.cause = 2'd3; total = fw + 3 + TO;
      end else begin
         e.isHalt        = 1'b0;
         e.lat           = zeroWaitLatency(k) - 1 + (ls ? mw : 0);
         e.pcSel         = (k == K_JUMP) || (k == K_BRANCH && taken);
         e.regWes        = (k inside {K_ALU, K_JUMP, K_LOAD}) ? 1 : 0;
         e.wbSel         = (k == K_LOAD) ? 2'd1 : (k == K_JUMP) ? 2'd2 : 2'd0;
         e.memCycles     = ls ? mw + 1 : 0;
         e.weCycles      = (k == K_STORE) ? mw + 1 : 0;
         e.instretBefore = CNT_W'(modelCount);
         modelCount      = (modelCount + 1) % (1 << CNT_W);
         total           = fw + zeroWaitLatency(k) + (ls ? mw : 0);
      end
      sbQ.push_back(e);
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         if (c == 0) begin
            opcode       = op;
            branch_taken = taken;
            run          = 1'b1;
         end
         mem_ready = (c == fw) || (ls && c == fw + 3 + mw);
      end
   endtask

   task automatic resetDut(input bit runAfter);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         rst = 1'b1; run = 1'b1; mem_ready = 1'b1;
         #4;
         checkOutput("strobes in reset", {mem_req, mem_we, ir_we, pc_we, reg_we}, 0);
         if (c == 1) begin
            checkOutput("reset state", state, 0);
            checkOutput("reset instret", instret, 0);
            checkOutput("reset halted", halted, 0);
            checkOutput("reset halt_cause", halt_cause, 0);
         end
      end
      @(negedge clk);
      rst = 1'b0; run = runAfter; mem_ready = 1'b0;
      #4;
      checkOutput("mem_req after reset", mem_req, runAfter);
      modelCount = 0;
   endtask

   task automatic checkHalted(input logic [1:0] cause);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         run = 1'b1; mem_ready = 1'b1;
         #4;
         checkOutput("halted", halted, 1);
         checkOutput("halt_cause", halt_cause, cause);
         checkOutput("strobes in halt", {mem_req, mem_we, ir_we, pc_we, reg_we}, 0);
         checkOutput("instret in halt", instret, modelCount);
      end
   endtask

   // Monitor: tracks per-instruction activity from ir_we and scores it on pc_we or a halt.
   always begin
      exp_t e;
      @(negedge clk);
      #4;
      if (rst) begin
         monPrevHalted = 1'b0;
      end else begin
         if (ir_we) begin
            monLat = 0; monMem = 0; monWe = 0; monReg = 0;
         end else begin
            monLat++;
         end
         if (mem_req && mem_addr_sel) monMem++;
         if (mem_we) monWe++;
         if (reg_we) monReg++;
         if (pc_we) begin
            checkOutput("retire expected", sbQ.size() > 0, 1);
            if (sbQ.size() > 0) begin
               e = sbQ.pop_front();
               checkOutput("event kind retire", 0, e.isHalt);
               if (!e.isHalt) begin
                  checkOutput("latency", monLat, e.lat);
                  checkOutput("pc_sel", pc_sel, e.pcSel);
                  checkOutput("reg_we count", monReg, e.regWes);
                  if (e.regWes != 0) checkOutput("wb_sel", wb_sel, e.wbSel);
                  checkOutput("mem data cycles", monMem, e.memCycles);
                  checkOutput("mem_we cycles", monWe, e.weCycles);
                  checkOutput("instret at retire", instret, e.instretBefore);
               end
            end
         end
         if (halted && !monPrevHalted) begin
            checkOutput("halt expected", sbQ.size() > 0, 1);
            if (sbQ.size() > 0) begin
               e = sbQ.pop_front();
               checkOutput("event kind halt", 1, e.isHalt);
               checkOutput("halt cause", halt_cause, e.cause);
            end
         end
         monPrevHalted = halted;
      end
   end

   initial begin
      rst = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 7'd0;
      branch_taken = 1'b0; is_store_hint = 1'b0;
      resetDut(1'b1);

      applyStimulus(7'b0010011, 0, 0, 1'b0);
      applyStimulus(7'b0000011, 0, 3, 1'b0);
      applyStimulus(7'b1100011, 0, 0, 1'b1);
      applyStimulus(7'b1100011, 0, 0, 1'b0);
      applyStimulus(7'b1101111, 1, 0, 1'b0);
      applyStimulus(7'b0100011, 0, 1, 1'b0);
      applyStimulus(7'b0010011, TO - 1, 0, 1'b0);
      applyStimulus(7'b0000011, 0, TO - 1, 1'b0);
      applyStimulus(7'b1111111, 0, 0, 1'b0);
`ifdef RISCV_CTRL_ILLEGAL_TRAP_EN
      checkHalted(2'd2);
      resetDut(1'b0);
`endif

      // Reset while a load is waiting in MEM.
      @(negedge clk); opcode = 7'b0000011; run = 1'b1; mem_ready = 1'b1;
      @(negedge clk); mem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk); #4;
      checkOutput("state in MEM", state, 3);
      @(negedge clk); rst = 1'b1; #4;
      checkOutput("strobes in mid-MEM reset", {mem_req, pc_we, reg_we}, 0);
      @(negedge clk); rst = 1'b0; run = 1'b0; #4;
      checkOutput("state after mid-MEM reset", state, 0);
      checkOutput("instret after mid-MEM reset", instret, 0);
      modelCount = 0;

      for (int i = 0; i < 60; i++)
         applyStimulus(randomOpcode(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));

      applyStimulus(7'b1110011, 0, 0, 1'b0);
      checkHalted(2'd1);
      resetDut(1'b0);
      applyStimulus(7'b0010011, TO, 0, 1'b0);
      checkHalted(2'd3);
      resetDut(1'b0);
      applyStimulus(7'b0100011, 0, TO, 1'b0);
      checkHalted(2'd3);
      resetDut(1'b0);
      applyStimulus(7'b0110011, 2, 0, 1'b0);

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         run = 1'b0; mem_ready = 1'b1;
         #4;
         checkOutput("idle fetch strobes", {mem_req, ir_we}, 0);
         checkOutput("idle state", state, 0);
      end
      @(negedge clk); @(negedge clk); #4;
      checkOutput("scoreboard drained", sbQ.size(), 0);
      checkOutput("final instret", instret, modelCount);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
